// File: rtl/dmem_byte_sequencer_if.sv
// MEM-stage request bus plus byte-wide memory port of the data-memory sequencer.
// master = pipeline/memory side, slave = sequencer.
interface dmem_byte_sequencer_if #(
  parameter int AW = 10
);
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic          stall;
  logic [31:0]   rdata;
  logic          rd_valid;
  logic          misalign;
  logic [AW-1:0] byte_addr;
  logic [7:0]    byte_wdata;
  logic          byte_we;
  logic          byte_re;
  logic [7:0]    byte_rdata;

  modport master (
    output mem_read, mem_write, addr, wdata, byte_rdata,
    input  stall, rdata, rd_valid, misalign, byte_addr, byte_wdata, byte_we, byte_re
  );

  modport slave (
    input  mem_read, mem_write, addr, wdata, byte_rdata,
    output stall, rdata, rd_valid, misalign, byte_addr, byte_wdata, byte_we, byte_re
  );
endinterface

// File: rtl/dmem_byte_sequencer.sv
// Splits a 32-bit load/store into four big-endian byte beats on a byte-wide sync memory.
// Store: 4 cycles to DONE, load: 5 cycles; pipeline held via combinational stall.
module dmem_byte_sequencer #(
  parameter int AW = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  dmem_byte_sequencer_if.slave     bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD      = 3'd2,
    RD_LAST = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t        state_q;
  logic [1:0]    k_q;
  logic [31:0]   wdata_q;
  logic [23:0]   shift_q;
  logic [31:0]   rdata_q;
  logic          rd_valid_q;
  logic          misalign_q;
  logic [AW-1:0] byte_addr_q;
  logic [7:0]    byte_wdata_q;
  logic          byte_we_q;
  logic          byte_re_q;

  logic          req;
  logic [1:0]    k_d;
  logic [AW-1:0] first_addr_d;
  logic [AW-1:0] next_addr_d;
  logic          stall;

  assign req          = bus.mem_read | bus.mem_write;
  assign k_d          = k_q + 2'd1;
  // Beat 0 is the MSB, three bytes below the addressed LSB; wraps modulo 2^AW.
  assign first_addr_d = bus.addr - AW'(3);
  assign next_addr_d  = byte_addr_q + AW'(1);

  always_comb begin
    stall = 1'b1;
    case (state_q)
      IDLE:    stall = req;
      DONE:    stall = 1'b0;
      default: stall = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      k_q          <= 2'd0;
      wdata_q      <= 32'd0;
      shift_q      <= 24'd0;
      rdata_q      <= 32'd0;
      rd_valid_q   <= 1'b0;
      misalign_q   <= 1'b0;
      byte_addr_q  <= '0;
      byte_wdata_q <= 8'd0;
      byte_we_q    <= 1'b0;
      byte_re_q    <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      rd_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            k_q         <= 2'd0;
            byte_addr_q <= first_addr_d;
            misalign_q  <= (bus.addr[1:0] != 2'b11);
            if (bus.mem_write) begin
              state_q      <= WR;
              byte_we_q    <= 1'b1;
              byte_wdata_q <= bus.wdata[31:24];
              wdata_q      <= {bus.wdata[23:0], 8'h00};
            end else begin
              state_q   <= RD;
              byte_re_q <= 1'b1;
            end
          end
        end
        WR: begin
          k_q <= k_d;
          if (k_q == 2'd3) begin
            state_q   <= DONE;
            byte_we_q <= 1'b0;
          end else begin
            byte_addr_q  <= next_addr_d;
            byte_wdata_q <= wdata_q[31:24];
            wdata_q      <= {wdata_q[23:0], 8'h00};
          end
        end
        RD: begin
          k_q <= k_d;
          // Memory data lags byte_re by one cycle, so beat k returns the byte of beat k-1.
          if (k_q != 2'd0) begin
            shift_q <= {shift_q[15:0], bus.byte_rdata};
          end
          if (k_q == 2'd3) begin
            state_q   <= RD_LAST;
            byte_re_q <= 1'b0;
          end else begin
            byte_addr_q <= next_addr_d;
          end
        end
        RD_LAST: begin
          rdata_q    <= {shift_q, bus.byte_rdata};
          rd_valid_q <= 1'b1;
          state_q    <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.stall      = stall;
  assign bus.rdata      = rdata_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.misalign   = misalign_q;
  assign bus.byte_addr  = byte_addr_q;
  assign bus.byte_wdata = byte_wdata_q;
  assign bus.byte_we    = byte_we_q;
  assign bus.byte_re    = byte_re_q;

endmodule

// File: doc/dmem_byte_sequencer.md
Name: dmem_byte_sequencer

Overview:
- Controller between the MEM pipeline stage and a single-ported, byte-wide (8-bit) synchronous data memory.
- Turns one 32-bit load or store request into four sequenced byte accesses, big-endian. The request address names the word's least-significant byte; the MSB sits at address-3.
- Holds the pipeline with `stall` until the word access completes.
- Returns assembled load data with a one-cycle valid pulse.

Parameters:
- AW, 10, byte address width (1 KiB memory).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- mem_read  in  1  MEM-stage load request, level, held while stall=1.
- mem_write  in  1  MEM-stage store request, level, held while stall=1.
- addr  in  AW  word address (LSB byte location), from EXE/MEM register.
- wdata  in  32  store data.
- stall  out  1  freeze pipeline registers.
- rdata  out  32  assembled load word.
- rd_valid  out  1  one-cycle pulse: rdata is new.
- misalign  out  1  one-cycle pulse at request acceptance when addr[1:0]!=2'b11.
- byte_addr  out  AW  memory byte address.
- byte_wdata  out  8  memory write byte.
- byte_we  out  1  memory write enable (memory writes on posedge when high).
- byte_re  out  1  memory read enable.
- byte_rdata  in  8  memory read byte; valid the cycle after byte_re was high at a posedge.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - rdata=0; rd_valid=0; misalign=0.
  - byte_we=0; byte_re=0; byte_addr=0; byte_wdata=0.
  - stall is combinational and therefore 0 (no request can be active in reset).
- States: IDLE, WR, RD, RD_LAST, DONE. Beat counter k is 2 bits.
- IDLE:
  - req = mem_read|mem_write.
  - stall = req, combinational in the same cycle.
  - On posedge with req: latch base=addr, wdata, and op (write wins if both are high).
  - Pulse misalign if addr[1:0]!=3. The access proceeds regardless.
  - k=0. Go to WR (write) or RD (read).
- Byte address for beat k: base-3+k, computed modulo 2^AW (wraps; base<3 wraps to the top of memory).
- Byte order: beat 0 is bits[31:24] (MSB) and beat 3 is bits[7:0].
- WR (4 cycles, k=0..3):
  - byte_we=1; byte_addr as above; byte_wdata = wdata byte for beat k.
  - stall=1.
  - After k=3, go to DONE.
- RD (4 cycles, k=0..3):
  - byte_re=1; byte_addr as above; stall=1.
  - From k=1 on, capture byte_rdata (the byte for beat k-1) into the shift/assembly register.
  - After k=3, go to RD_LAST.
- RD_LAST (1 cycle):
  - byte_re=0; stall=1.
  - Capture the beat-3 byte; load the completed word into rdata.
  - Go to DONE.
- DONE (1 cycle):
  - stall=0.
  - rd_valid=1 only if the op was a read; rdata is stable here and holds until the next read completes.
  - byte_we and byte_re are 0.
  - The pipeline advances at this edge. The controller ignores req this cycle and returns to IDLE unconditionally. A new request is then accepted the following cycle, so there are no duplicate accesses for the same request.
- Latency from acceptance edge to DONE: store 4 cycles; load 5 cycles.
- Total stall cycles per request: store 5; load 6 (includes the IDLE acceptance cycle).
- Request changes while busy: ignored; latched values are used. Dropping req mid-sequence does not abort.
- rst_n asserted mid-operation: abort immediately to IDLE with all outputs at reset values. The memory holds whatever bytes were already written.
- byte_we and byte_re are never both high.

Test Plan:
1. Store then load, happy path.
   - Store addr=7, wdata=0xA1B2C3D4 → byte writes 4:A1, 5:B2, 6:C3, 7:D4 on four consecutive cycles; stall high 5 cycles.
   - Then load addr=7 → rdata=0xA1B2C3D4 with rd_valid for exactly 1 cycle; stall high 6 cycles.
2. Preloaded memory read.
   - Memory preloaded with mem[i]=i+1 where (i+1)%4==0, else 0.
   - Load addr=31 → rdata=0x00000020; load addr=3 → 0x00000004.
3. Wrap and misalignment.
   - Store addr=1, wdata=0x11223344 → bytes at 1022:11, 1023:22, 0:33, 1:44; misalign pulses once.
   - Load addr=1 → 0x11223344.
4. Simultaneous requests and back-to-back.
   - mem_read=mem_write=1 at addr=11 → treated as a store, no byte_re, rd_valid stays 0.
   - Request held high through DONE → next access starts exactly 1 cycle after DONE, one per request.
5. Reset mid-access.
   - Assert rst_n=0 during RD at k=2 → all outputs 0 asynchronously, state IDLE.
   - After release, a load at addr=7 completes normally.
